pe_chain_ctrl: RTL

Sequencer for a linear chain of `NUM_PE` processing elements (weight-stationary, registered multiply-accumulate stages).
- Per job: fetches one weight per PE from weight memory, then streams `cfg_len` activation words from activation memory into the chain.
- Tracks in-flight data through the chain's fixed pipeline latency so it can flag each valid output partial sum and signal job completion.
- Sits between the job-issue logic and the PE chain plus its two read-only SRAMs (1-cycle read latency).

---
 rtl/pe_ctrl_pkg.sv | 22 ++
 rtl/valid_delay_line.sv | 35 +++
 rtl/pe_chain_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pe_ctrl_pkg.sv
// Shared types for the PE chain sequencer: FSM state encoding and the
// default chain pipeline depth.
package pe_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } state_e;

    localparam int DEF_NUM_PE = 8;
    localparam int DEF_PE_LAT = 2;
    localparam int D          = DEF_NUM_PE * DEF_PE_LAT;

    // Valid-pipe depth equals the end-to-end latency of the PE chain.
    function automatic int pipe_depth(input int num_pe, input int pe_lat);
        return num_pe * pe_lat;
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// DEPTH-stage valid shift register with synchronous clear. any_valid reports
// whether any valid bit is still in the line on the next cycle.
module valid_delay_line #(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic din,
    output logic dout,
    output logic any_valid
);

    logic [DEPTH-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d = '0;
        if (!clr) begin
            pipe_d = DEPTH'({pipe_q, din});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout      = pipe_q[DEPTH-1];
    // Looks at next-cycle contents so the owner can retire on the final output.
    assign any_valid = |pipe_d;

endmodule

// File: rtl/pe_chain_ctrl.sv
// Job sequencer for a weight-stationary PE chain: weight preload, activation
// streaming, output tracking. Optional PE_CTRL_PERF_CNT_EN adds perf_cycles.
module pe_chain_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int NUM_PE = DEF_NUM_PE,
    parameter int PE_LAT = DEF_PE_LAT,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [LEN_W-1:0]          cfg_len,
    input  logic [ADDR_W-1:0]         cfg_w_base,
    input  logic [ADDR_W-1:0]         cfg_a_base,
    output logic                      busy,
    output logic                      done,
    output logic                      w_rd_en,
    output logic [ADDR_W-1:0]         w_rd_addr,
    output logic                      w_load_en,
    output logic [$clog2(NUM_PE)-1:0] w_load_idx,
    output logic                      act_rd_en,
    output logic [ADDR_W-1:0]         act_rd_addr,
    output logic                      act_valid,
    output logic                      out_valid,
    output logic [LEN_W-1:0]          out_idx
`ifdef PE_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]               perf_cycles
`endif
);

    localparam int DEPTH = pipe_depth(NUM_PE, PE_LAT);
    localparam int IDX_W = $clog2(NUM_PE);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]  a_base_q, a_base_d;
    logic [IDX_W-1:0]   w_cnt_q, w_cnt_d;
    logic [LEN_W-1:0]   a_cnt_q, a_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               w_rd_en_q, w_rd_en_d;
    logic [ADDR_W-1:0]  w_rd_addr_q, w_rd_addr_d;
    logic               w_load_en_q, w_load_en_d;
    logic [IDX_W-1:0]   w_load_idx_q, w_load_idx_d;
    logic               act_rd_en_q, act_rd_en_d;
    logic [ADDR_W-1:0]  act_rd_addr_q, act_rd_addr_d;
    logic               act_valid_q, act_valid_d;
    logic [LEN_W-1:0]   out_idx_q, out_idx_d;
    logic               pipe_clr;
    logic               pipe_out;
    logic               pipe_any;

    valid_delay_line #(
        .DEPTH(DEPTH)
    ) u_vld_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (pipe_clr),
        .din      (act_valid_q),
        .dout     (pipe_out),
        .any_valid(pipe_any)
    );

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        a_base_d      = a_base_q;
        w_cnt_d       = w_cnt_q;
        a_cnt_d       = a_cnt_q;
        done_d        = 1'b0;
        w_rd_en_d     = 1'b0;
        w_rd_addr_d   = w_rd_addr_q;
        w_load_en_d   = w_rd_en_q;
        w_load_idx_d  = w_cnt_q;
        act_rd_en_d   = 1'b0;
        act_rd_addr_d = act_rd_addr_q;
        act_valid_d   = act_rd_en_q;
        out_idx_d     = pipe_out ? out_idx_q + LEN_W'(1) : out_idx_q;
        pipe_clr      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = LOAD_W;
                    len_d       = cfg_len;
                    a_base_d    = cfg_a_base;
                    w_cnt_d     = '0;
                    w_rd_en_d   = 1'b1;
                    w_rd_addr_d = cfg_w_base;
                    out_idx_d   = '0;
                end
            end
            LOAD_W: begin
                if (w_cnt_q == IDX_W'(NUM_PE - 1)) begin
                    if (len_q == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d       = STREAM;
                        a_cnt_d       = '0;
                        act_rd_en_d   = 1'b1;
                        act_rd_addr_d = a_base_q;
                    end
                end else begin
                    w_cnt_d     = w_cnt_q + IDX_W'(1);
                    w_rd_en_d   = 1'b1;
                    w_rd_addr_d = w_rd_addr_q + ADDR_W'(1);
                end
            end
            STREAM: begin
                if (a_cnt_q == len_q - LEN_W'(1)) begin
                    state_d = DRAIN;
                end else begin
                    a_cnt_d       = a_cnt_q + LEN_W'(1);
                    act_rd_en_d   = 1'b1;
                    act_rd_addr_d = act_rd_addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                // Retire so that done lands the cycle after the last output.
                if (!pipe_any) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && state_q != IDLE) begin
            state_d     = IDLE;
            done_d      = 1'b0;
            w_rd_en_d   = 1'b0;
            w_load_en_d = 1'b0;
            act_rd_en_d = 1'b0;
            act_valid_d = 1'b0;
            pipe_clr    = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            len_q         <= '0;
            a_base_q      <= '0;
            w_cnt_q       <= '0;
            a_cnt_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            w_rd_en_q     <= 1'b0;
            w_rd_addr_q   <= '0;
            w_load_en_q   <= 1'b0;
            w_load_idx_q  <= '0;
            act_rd_en_q   <= 1'b0;
            act_rd_addr_q <= '0;
            act_valid_q   <= 1'b0;
            out_idx_q     <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            a_base_q      <= a_base_d;
            w_cnt_q       <= w_cnt_d;
            a_cnt_q       <= a_cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            w_rd_en_q     <= w_rd_en_d;
            w_rd_addr_q   <= w_rd_addr_d;
            w_load_en_q   <= w_load_en_d;
            w_load_idx_q  <= w_load_idx_d;
            act_rd_en_q   <= act_rd_en_d;
            act_rd_addr_q <= act_rd_addr_d;
            act_valid_q   <= act_valid_d;
            out_idx_q     <= out_idx_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign w_rd_en     = w_rd_en_q;
    assign w_rd_addr   = w_rd_addr_q;
    assign w_load_en   = w_load_en_q;
    assign w_load_idx  = w_load_idx_q;
    assign act_rd_en   = act_rd_en_q;
    assign act_rd_addr = act_rd_addr_q;
    assign act_valid   = act_valid_q;
    assign out_valid   = pipe_out;
    assign out_idx     = out_idx_q;

`ifdef PE_CTRL_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == IDLE && start) begin
            perf_d = '0;
        end else if (busy_q && perf_q != '1) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule
